// File: rtl/dmem_bytelane.sv
// Byte-lane aware data memory for the single-cycle RISC-V core.
// Handles B/H/W loads and stores with extension, reports access errors and clears itself with a sequential scrub.
module dmem_bytelane #(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned IDX_W    = 7,
  parameter int unsigned TEST_IDX = 100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [2:0]  FUNCT3,
  input  logic        CLR_REQ,
  output logic [31:0] RD,
  output logic        READY,
  output logic [1:0]  ERR,
  output logic        ERR_STICKY,
  output logic [31:0] TEST
);

  typedef enum logic {
    S_SCRUB = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ALIGN = 2'b01;
  localparam logic [1:0] E_RANGE = 2'b10;
  localparam logic [1:0] E_ILL   = 2'b11;

  logic [31:0]      r_mem [DEPTH];
  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_err_sticky;

  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_err;
  logic             w_store;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_word;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_rd;

  assign w_idx = A[IDX_W+1:2];

  // Error code, highest priority first: illegal funct3, misaligned, out-of-range
  always_comb begin
    w_err = E_NONE;
    if (FUNCT3 == 3'b011 || FUNCT3 == 3'b110 || FUNCT3 == 3'b111 ||
        ((FUNCT3 == F_BU || FUNCT3 == F_HU) && WE))
      w_err = E_ILL;
    else if (((FUNCT3 == F_H || FUNCT3 == F_HU) && A[0]) ||
             (FUNCT3 == F_W && A[1:0] != 2'b00))
      w_err = E_ALIGN;
    else if (|A[31:IDX_W+2])
      w_err = E_RANGE;
  end

  assign w_store = WE && r_ready && (r_state == S_IDLE) && (w_err == E_NONE) && !CLR_REQ;

  // Lane enables and replicated store data so each lane sees its own bytes
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = WD;
    case (FUNCT3)
      F_B: begin
        w_be             = 4'b0000;
        w_be[A[1:0]]     = 1'b1;
        w_wdata          = {4{WD[7:0]}};
      end
      F_H: begin
        w_be    = A[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WD[15:0]}};
      end
      F_W: begin
        w_be    = 4'b1111;
        w_wdata = WD;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = WD;
      end
    endcase
  end

  // Array has no reset; the scrub engine owns it while scrubbing
  always_ff @(posedge CLK) begin
    if (r_state == S_SCRUB) begin
      r_mem[r_cnt] <= '0;
    end else if (w_store) begin
      for (int l = 0; l < 4; l++) begin
        if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= S_SCRUB;
      r_cnt        <= '0;
      r_ready      <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      case (r_state)
        S_SCRUB: begin
          r_cnt <= r_cnt + IDX_W'(1);
          if (r_cnt == IDX_W'(DEPTH - 1)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (CLR_REQ) begin
            r_state      <= S_SCRUB;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_err_sticky <= 1'b0;
          end else if (WE && r_ready && (w_err != E_NONE)) begin
            r_err_sticky <= 1'b1;
          end
        end
      endcase
    end
  end

  assign w_word = r_mem[w_idx];

  always_comb begin
    case (A[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  assign w_half = A[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_rd = '0;
    if (r_ready && (w_err == E_NONE)) begin
      case (FUNCT3)
        F_B:     w_rd = {{24{w_byte[7]}}, w_byte};
        F_H:     w_rd = {{16{w_half[15]}}, w_half};
        F_W:     w_rd = w_word;
        F_BU:    w_rd = {24'h0, w_byte};
        F_HU:    w_rd = {16'h0, w_half};
        default: w_rd = '0;
      endcase
    end
  end

  assign RD         = w_rd;
  assign ERR        = w_err;
  assign READY      = r_ready;
  assign ERR_STICKY = r_err_sticky;
  assign TEST       = r_mem[IDX_W'(TEST_IDX)];

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed self-checking bench for dmem_bytelane (DEPTH=128, TEST_IDX=100).
module tb_dmem_bytelane;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic [2:0]  FUNCT3;
  logic        CLR_REQ;
  logic [31:0] RD;
  logic        READY;
  logic [1:0]  ERR;
  logic        ERR_STICKY;
  logic [31:0] TEST;

  int total = 0;
  int bad   = 0;

  dmem_bytelane #(.DEPTH(128), .IDX_W(7), .TEST_IDX(100)) dut (
    .CLK(CLK), .RST(RST), .A(A), .WD(WD), .WE(WE), .FUNCT3(FUNCT3),
    .CLR_REQ(CLR_REQ), .RD(RD), .READY(READY), .ERR(ERR),
    .ERR_STICKY(ERR_STICKY), .TEST(TEST)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    FUNCT3 = f3; A = addr; WD = data; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] exp);
    FUNCT3 = f3; A = addr; WE = 1'b0;
    #1;
    chk(tag, RD, exp);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (READY !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
  endtask

  int n;
  int nz;

  initial begin
    RST = 1'b0; A = '0; WD = '0; WE = 1'b0; FUNCT3 = 3'b010; CLR_REQ = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(READY), 32'd0);
    chk("rst_sticky", 32'(ERR_STICKY), 32'd0);

    // Initial scrub length and cleared contents
    RST = 1'b1;
    wait_ready(n);
    chk("scrub_len", 32'(n), 32'd128);
    chk("test_zero", TEST, 32'h0);
    nz = 0;
    for (int i = 0; i < 128; i++) begin
      A = 32'(i * 4); FUNCT3 = 3'b010;
      #1;
      if (RD !== 32'h0) nz++;
    end
    chk("all_zero", 32'(nz), 32'd0);

    // Byte-lane stores and extended loads
    store(3'b010, 32'h8, 32'h11223344);
    store(3'b000, 32'h9, 32'h000000AA);
    store(3'b001, 32'hA, 32'h0000BEEF);
    load("lw8",   3'b010, 32'h8, 32'hBEEFAA44);
    load("lb9",   3'b000, 32'h9, 32'hFFFFFFAA);
    load("lbu9",  3'b100, 32'h9, 32'h000000AA);
    load("lha",   3'b001, 32'hA, 32'hFFFFBEEF);
    load("lhua",  3'b101, 32'hA, 32'h0000BEEF);
    load("lb8",   3'b000, 32'h8, 32'h00000044);
    load("lh8",   3'b001, 32'h8, 32'hFFFFAA44);

    // Store is visible on RD only after the edge
    FUNCT3 = 3'b010; A = 32'hC; WD = 32'h55667788; WE = 1'b1;
    #1;
    chk("pre_edge_rd", RD, 32'h0);
    tick();
    WE = 1'b0;
    load("post_edge_rd", 3'b010, 32'hC, 32'h55667788);

    // Rejected stores
    store(3'b010, 32'h0, 32'h12345678);
    FUNCT3 = 3'b010; A = 32'h6; WD = 32'hDEADDEAD; WE = 1'b1;
    #1;
    chk("err_sw6", 32'(ERR), 32'd1);
    chk("sticky_pre", 32'(ERR_STICKY), 32'd0);
    tick();
    WE = 1'b0;
    chk("sticky_set", 32'(ERR_STICKY), 32'd1);
    load("w1_unchanged", 3'b010, 32'h4, 32'h0);

    FUNCT3 = 3'b001; A = 32'h3; WD = 32'h0000FFFF; WE = 1'b1;
    #1;
    chk("err_sh3", 32'(ERR), 32'd1);
    tick();
    WE = 1'b0;
    load("w0_after_sh3", 3'b010, 32'h0, 32'h12345678);

    FUNCT3 = 3'b010; A = 32'h200; WD = 32'h0; WE = 1'b1;
    #1;
    chk("err_oor", 32'(ERR), 32'd2);
    tick();
    WE = 1'b0;
    load("w0_after_oor", 3'b010, 32'h0, 32'h12345678);
    load("lw_oor_rd", 3'b010, 32'h200, 32'h0);
    chk("lw_oor_err", 32'(ERR), 32'd2);
    load("lw_mis_oor", 3'b010, 32'h202, 32'h0);
    chk("align_over_range", 32'(ERR), 32'd1);

    // Illegal funct3
    FUNCT3 = 3'b011; A = 32'h201; WD = 32'hFFFFFFFF; WE = 1'b1;
    #1;
    chk("err_f011", 32'(ERR), 32'd3);
    tick();
    FUNCT3 = 3'b100; A = 32'h0; WE = 1'b1;
    #1;
    chk("err_f100_we", 32'(ERR), 32'd3);
    tick();
    WE = 1'b0;
    load("w0_after_ill", 3'b010, 32'h0, 32'h12345678);
    load("lbu_ok", 3'b100, 32'h0, 32'h00000078);
    chk("err_f100_rd", 32'(ERR), 32'd0);

    // Probe word
    FUNCT3 = 3'b010; A = 32'h190; WD = 32'hCAFEF00D; WE = 1'b1;
    #1;
    chk("test_pre", TEST, 32'h0);
    tick();
    WE = 1'b0;
    chk("test_post", TEST, 32'hCAFEF00D);

    // Clear request with a coincident store: store dropped, sticky cleared
    FUNCT3 = 3'b010; A = 32'h190; WD = 32'h0BADBEEF; WE = 1'b1; CLR_REQ = 1'b1;
    tick();
    WE = 1'b0; CLR_REQ = 1'b0;
    chk("clr_ready", 32'(READY), 32'd0);
    chk("clr_sticky", 32'(ERR_STICKY), 32'd0);
    chk("clr_drop", TEST, 32'hCAFEF00D);
    load("clr_rd_gated", 3'b010, 32'h8, 32'h0);
    wait_ready(n);
    chk("clr_len", 32'(n), 32'd128);
    chk("clr_test", TEST, 32'h0);
    load("clr_w2", 3'b010, 32'h8, 32'h0);

    // Reset pulse in the middle of a scrub restarts it
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    repeat (50) tick();
    RST = 1'b0;
    #1;
    chk("midrst_ready", 32'(READY), 32'd0);
    tick();
    RST = 1'b1;
    wait_ready(n);
    chk("midrst_len", 32'(n), 32'd128);

    // Stores and clear requests during a scrub are ignored
    store(3'b010, 32'h190, 32'h13579BDF);
    chk("test_pre_scrub", TEST, 32'h13579BDF);
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    n = 0;
    while (READY !== 1'b1 && n < 1000) begin
      tick();
      n++;
      CLR_REQ = (n == 60);
      WE      = (n >= 110 && n < 118);
      A       = (n < 115) ? 32'h190 : 32'h6;
      WD      = 32'h77777777;
      FUNCT3  = 3'b010;
      if (n == 116) begin
        #1;
        chk("scrub_err", 32'(ERR), 32'd1);
        chk("scrub_rd", RD, 32'h0);
      end
    end
    WE = 1'b0; CLR_REQ = 1'b0;
    chk("scrub2_len", 32'(n), 32'd128);
    chk("scrub2_test", TEST, 32'h0);
    chk("scrub2_sticky", 32'(ERR_STICKY), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised data memory for the single-cycle RISC-V core. It replaces the word-only data memory with a RISC-V load/store-aware block.
- Supports byte, half-word and word accesses via funct3, with sign or zero extension on loads and error detection.
- Clears memory with a sequential scrub engine instead of a single-cycle array reset, and exposes a configurable probe word for testbenches.

Parameters:
- DEPTH, 128, number of 32-bit words; must be a power of two, at least 4.
- IDX_W, 7, word-index width; must equal log2(DEPTH).
- TEST_IDX, 100, word index driven onto TEST; must be less than DEPTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- A  input  32  byte address.
- WD  input  32  store data, right-aligned.
- WE  input  1  store enable.
- FUNCT3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- CLR_REQ  input  1  request a full memory scrub.
- RD  output  32  load data, extended.
- READY  output  1  1 when memory is usable; 0 while scrubbing.
- ERR  output  2  combinational access error code.
- ERR_STICKY  output  1  latched 1 when a store was rejected because of ERR.
- TEST  output  32  raw contents of MEM[TEST_IDX].

Behaviour:
- Word index is A[IDX_W+1:2]. The address is out-of-range when A[31:IDX_W+2] is non-zero.
- ERR is combinational with priority:
  - 11: illegal FUNCT3, meaning 011, 110 or 111; also 100 or 101 when WE=1.
  - 01: misaligned; H/HU with A[0]=1, or W with A[1:0] not equal to 00.
  - 10: out-of-range.
  - 00: no error.
- Stores, taken on the rising edge when WE=1, READY=1, ERR=00 and CLR_REQ=0:
  - B writes WD[7:0] to byte lane A[1:0].
  - H writes WD[15:0] to half lane A[1].
  - W writes the full word.
  - Other lanes are unchanged.
- Loads are combinational from the current array contents:
  - B/H: sign-extend the selected lane.
  - BU/HU: zero-extend the selected lane.
  - W: the full word.
  - RD=0 when ERR is not 00 or READY=0.
  - A store in the same cycle is visible on RD only after the edge.
- The array is not asynchronously reset.
- Reset (RST=0) forces:
  - state=SCRUB, cnt=0, READY=0, ERR_STICKY=0.
  - TEST is unaffected except through scrub progress.
- FSM states:
  - SCRUB: each cycle writes MEM[cnt]=0 and increments cnt. When cnt==DEPTH-1 the final write occurs, the next state is IDLE and READY=1 from the following cycle. A scrub takes exactly DEPTH cycles after RST deasserts.
  - IDLE: normal operation. CLR_REQ=1 sets state=SCRUB, cnt=0 and READY=0 next cycle, and clears ERR_STICKY. A store coincident with CLR_REQ is dropped.
- In SCRUB: WE is ignored, CLR_REQ is ignored (the scrub is not restarted), and ERR still reports combinationally.
- ERR_STICKY:
  - Set on the edge when WE=1, READY=1 and ERR is not 00.
  - Cleared only by reset or an accepted CLR_REQ.
- Reset asserted mid-scrub or mid-operation restarts the scrub from cnt=0.
- A scrub step and an IDLE store never write in the same cycle.

Test Plan:
- Release RST, then count cycles -> READY=0 for exactly DEPTH (128) cycles, then 1. TEST=0 and every word reads 0 via LW.
- SW 0x11223344 @0x8; SB 0xAA @0x9; SH 0xBEEF @0xA. Then LW @0x8 -> 0xBEEFAA44; LB @0x9 -> 0xFFFFFFAA; LBU @0x9 -> 0x000000AA; LH @0xA -> 0xFFFFBEEF; LHU @0xA -> 0x0000BEEF.
- SW @0x6 (misaligned), SH @0x3, and SW @0x200 (out-of-range, DEPTH=128):
  - ERR=01, 01 and 10 respectively.
  - Memory is unchanged; ERR_STICKY=1 after the first rejected store.
  - LW @0x200 -> RD=0.
- FUNCT3=011 with WE=1, and FUNCT3=100 with WE=1 -> ERR=11, no write. FUNCT3=100 with WE=0 -> ERR=00, load valid.
- SW 0xCAFEF00D @0x190 (word 100) -> TEST=0xCAFEF00D next cycle.
- Assert CLR_REQ together with WE -> the store is dropped, READY=0 for 128 cycles, then TEST=0 and ERR_STICKY=0.
- Pulse RST low at scrub cycle 50 -> the scrub restarts and READY rises 128 cycles after release.
- WE pulses during the scrub -> no effect.
